// File: rtl/stopwatch_bcd_counter.sv
// Stopwatch timebase and MM:SS.cc BCD digit chain feeding the seven-segment decoders.
// Optional lap freeze is compiled in with `define STOPWATCH_LAP_EN.

// One BCD digit of the cascade: increments on carry-in and wraps to 0 after MAX.
module sw_bcd_digit #(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic [3:0] cur,
  input  logic       cin,
  output logic [3:0] nxt,
  output logic       cout
);
  // >= keeps the digit legal even if it ever held an out-of-range value
  assign cout = cin && (cur >= MAX);

  always_comb begin
    nxt = cur;
    if (cin) nxt = (cur >= MAX) ? 4'd0 : cur + 4'd1;
  end
endmodule

module stopwatch_bcd_counter #(
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic [3:0] cs_ones,
  output logic [3:0] cs_tens,
  output logic [3:0] s_ones,
  output logic [3:0] s_tens,
  output logic [3:0] m_ones,
  output logic [3:0] m_tens,
  output logic       running,
  output logic       ovf,
  output logic       lap_active
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
  localparam int ND  = 6;
  localparam logic [ND-1:0][3:0] DMAX = {4'd5, 4'd9, 4'd5, 4'd9, 4'd9, 4'd9};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  state_t             st_q, st_d;
  logic [PW-1:0]      pre_q, pre_d;
  logic [ND-1:0][3:0] dig_q, dig_inc, disp;
  logic [ND:0]        carry;
  logic               tick, at_limit;

  // carry[ND] is high only when every digit sits at its maximum, i.e. 59:59.99
  assign carry[0] = 1'b1;
  assign at_limit = carry[ND];
  assign tick     = (st_q == S_RUN) && (pre_q == PRE_LAST);

  generate
    for (genvar g = 0; g < ND; g++) begin : g_dig
      sw_bcd_digit #(.MAX(DMAX[g])) u_dig (
        .cur (dig_q[g]),
        .cin (carry[g]),
        .nxt (dig_inc[g]),
        .cout(carry[g+1])
      );
    end
  endgenerate

  always_comb begin
    st_d  = st_q;
    pre_d = pre_q;
    case (st_q)
      S_IDLE:  if (start_stop) begin st_d = S_RUN; pre_d = '0; end
      S_RUN: begin
        pre_d = tick ? '0 : pre_q + 1'b1;
        // a tick coinciding with start_stop still completes before pausing
        if (tick && at_limit) st_d = S_DONE;
        else if (start_stop)  st_d = S_PAUSE;
      end
      S_PAUSE: if (start_stop) st_d = S_RUN;
      default: ;
    endcase
    if (clear) begin
      st_d  = S_IDLE;
      pre_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= S_IDLE;
      pre_q   <= '0;
      running <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      st_q    <= st_d;
      pre_q   <= pre_d;
      running <= (st_d == S_RUN);
      ovf     <= (st_d == S_DONE);
    end
  end

  // digits are written only on clear or a non-limit tick; they hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 dig_q <= '0;
    else if (clear)             dig_q <= '0;
    else if (tick && !at_limit) dig_q <= dig_inc;
  end

`ifdef STOPWATCH_LAP_EN
  logic [ND-1:0][3:0] snap_q;
  logic               lap_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_q <= '0;
      lap_q  <= 1'b0;
    end else if (clear || (tick && at_limit)) begin
      lap_q  <= 1'b0;
    end else if (lap && (st_q == S_RUN || st_q == S_PAUSE)) begin
      if (!lap_q) snap_q <= dig_q;
      lap_q <= !lap_q;
    end
  end

  assign disp       = lap_q ? snap_q : dig_q;
  assign lap_active = lap_q;
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign disp       = dig_q;
  assign lap_active = 1'b0;
`endif

  assign cs_ones = disp[0];
  assign cs_tens = disp[1];
  assign s_ones  = disp[2];
  assign s_tens  = disp[3];
  assign m_ones  = disp[4];
  assign m_tens  = disp[5];
endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// Stopwatch bench: directed latency/limit/lap scenarios plus random button pulses,
// all compared against a centisecond-count reference model.
module tb_stopwatch_bcd_counter;
  localparam int CLK_HZ = 1000, TICK_HZ = 100, DIV = CLK_HZ / TICK_HZ;
  localparam int LIMIT = 359999;
`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic start_stop = 1'b0, clear = 1'b0, lap = 1'b0;
  logic [3:0] cs_ones, cs_tens, s_ones, s_tens, m_ones, m_tens;
  logic running, ovf, lap_active;
  logic [23:0] disp, pre_v;

  assign disp = {m_tens, m_ones, s_tens, s_ones, cs_tens, cs_ones};

  stopwatch_bcd_counter #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) dut (
    .clk(clk), .rst_n(rst_n), .start_stop(start_stop), .clear(clear), .lap(lap),
    .cs_ones(cs_ones), .cs_tens(cs_tens), .s_ones(s_ones), .s_tens(s_tens),
    .m_ones(m_ones), .m_tens(m_tens), .running(running), .ovf(ovf),
    .lap_active(lap_active)
  );

  always #5 clk = ~clk;

  typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_DONE} mst_t;
  mst_t m_st  = M_IDLE;
  int   m_cnt = 0, m_pre = 0, m_snap = 0;
  bit   m_lap = 1'b0;
  int   errors = 0, checks = 0;

  function automatic logic [23:0] to_bcd(input int c);
    int cs, s, m;
    cs = c % 100;
    s  = (c / 100) % 60;
    m  = c / 6000;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(cs / 10), 4'(cs % 10)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // time as a plain centisecond count; a tick happens every DIV running cycles
  task automatic model_step(input bit ss, input bit clr, input bit lp);
    mst_t ost = m_st;
    int   old = m_cnt;
    bit   done_now = 1'b0;
    if (clr) begin
      m_st = M_IDLE; m_cnt = 0; m_pre = 0; m_lap = 1'b0;
      return;
    end
    case (m_st)
      M_IDLE: if (ss) begin m_st = M_RUN; m_pre = 0; end
      M_RUN: begin
        if (m_pre == DIV - 1) begin
          m_pre = 0;
          if (m_cnt == LIMIT) begin m_st = M_DONE; done_now = 1'b1; end
          else m_cnt++;
        end else m_pre++;
        if (ss && !done_now) m_st = M_PAUSE;
      end
      M_PAUSE: if (ss) m_st = M_RUN;
      default: ;
    endcase
    if (LAP_EN) begin
      if (done_now) m_lap = 1'b0;
      else if (lp && (ost == M_RUN || ost == M_PAUSE)) begin
        if (!m_lap) m_snap = old;
        m_lap = !m_lap;
      end
    end
  endtask

  task automatic check_all();
    chk("digits", disp, to_bcd(m_lap ? m_snap : m_cnt));
    chk("running", running, m_st == M_RUN);
    chk("ovf", ovf, m_st == M_DONE);
    chk("lap_active", lap_active, m_lap);
  endtask

  // inputs set just after a falling edge, sampled at the rising edge, checked at the next falling edge
  task automatic cyc(input bit ss, input bit clr, input bit lp);
    start_stop = ss; clear = clr; lap = lp;
    @(posedge clk);
    model_step(ss, clr, lp);
    #1;
    start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
    @(negedge clk);
    check_all();
  endtask

  task automatic preload(input int c);
    pre_v = to_bcd(c);
    force dut.dig_q = pre_v;
    #1;
    release dut.dig_q;
    m_cnt = c;
    #1;
    chk("preload", disp, to_bcd(c));
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    chk("rst_digits", disp, 24'h0);
    chk("rst_running", running, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_lap", lap_active, 1'b0);
    rst_n = 1'b1;
    repeat (3) cyc(0, 0, 0);

    // start latency and early counting
    cyc(1, 0, 0);
    chk("start_running", running, 1'b1);
    repeat (9) cyc(0, 0, 0);
    chk("lat_e9", disp, 24'h000000);
    cyc(0, 0, 0);
    chk("lat_e10", disp, 24'h000001);
    repeat (90) cyc(0, 0, 0);
    chk("e100", disp, 24'h000010);
    repeat (890) cyc(0, 0, 0);
    chk("cs99", disp, 24'h000099);
    repeat (10) cyc(0, 0, 0);
    chk("sec_carry", disp, 24'h000100);

    // minute carry from a preloaded 00:59.99
    cyc(1, 0, 0);
    preload(5999);
    cyc(1, 0, 0);
    n = 0;
    while (m_cnt != 6000 && n < 20) begin cyc(0, 0, 0); n++; end
    chk("min_carry", disp, 24'h010000);

    // pause holds digits and the partial prescaler interval
    repeat (3) cyc(0, 0, 0);
    cyc(1, 0, 0);
    repeat (50) cyc(0, 0, 0);
    chk("pause_hold", disp, 24'h010000);
    chk("pause_running", running, 1'b0);
    cyc(1, 0, 0);
    repeat (5) cyc(0, 0, 0);
    chk("resume_r5", disp, 24'h010000);
    cyc(0, 0, 0);
    chk("resume_r6", disp, 24'h010001);

    // limit: holds at 59:59.99 and raises ovf
    cyc(1, 0, 0);
    preload(LIMIT);
    cyc(1, 0, 0);
    n = 0;
    while (m_st != M_DONE && n < 20) begin cyc(0, 0, 0); n++; end
    chk("limit_digits", disp, 24'h595999);
    chk("limit_ovf", ovf, 1'b1);
    chk("limit_running", running, 1'b0);
    repeat (15) cyc(0, 0, 0);
    cyc(1, 0, 0);
    chk("done_ss_digits", disp, 24'h595999);
    chk("done_ss_ovf", ovf, 1'b1);
    cyc(0, 1, 0);
    chk("clr_digits", disp, 24'h0);
    chk("clr_ovf", ovf, 1'b0);

    // clear beats a coincident start_stop
    cyc(1, 0, 0);
    repeat (37) cyc(0, 0, 0);
    cyc(1, 1, 0);
    chk("clr_ss_running", running, 1'b0);
    chk("clr_ss_digits", disp, 24'h0);
    cyc(1, 0, 0);
    chk("idle_restart", running, 1'b1);
    cyc(0, 1, 0);

    // lap freeze and release
    cyc(1, 0, 0);
    repeat (120) cyc(0, 0, 0);
    cyc(0, 0, 1);
    chk("lap1_digits", disp, 24'h000012);
    chk("lap1_active", lap_active, LAP_EN);
    repeat (79) cyc(0, 0, 0);
    chk("lap_hold", disp, LAP_EN ? 24'h000012 : 24'h000020);
    repeat (220) cyc(0, 0, 0);
    cyc(0, 0, 1);
    chk("lap2_digits", disp, 24'h000042);
    chk("lap2_active", lap_active, 1'b0);

    // random button traffic
    for (int i = 0; i < 4000; i++)
      cyc($urandom_range(0, 39) == 0, $urandom_range(0, 299) == 0, $urandom_range(0, 29) == 0);

    // asynchronous reset mid-count
    cyc(0, 1, 0);
    cyc(1, 0, 0);
    repeat (137) cyc(0, 0, 0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_digits", disp, 24'h0);
    chk("arst_running", running, 1'b0);
    chk("arst_ovf", ovf, 1'b0);
    chk("arst_lap", lap_active, 1'b0);
    m_st = M_IDLE; m_cnt = 0; m_pre = 0; m_lap = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) cyc(0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/stopwatch_bcd_counter.md
Name: stopwatch_bcd_counter

Overview:
- Timebase and digit-counter stage of the stopwatch, directly upstream of the BCD-to-seven-segment decoders.
- Divides the system clock to a 10 ms tick and counts MM:SS.cc as six BCD digits, one per decoder instance.
- Run/pause/clear control comes from already-debounced, single-cycle button pulses.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- TICK_HZ, 100, count rate in Hz (centisecond resolution). DIV = CLK_HZ/TICK_HZ; CLK_HZ must be an integer multiple of TICK_HZ, DIV >= 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start_stop  input  1  single-cycle pulse; toggles run/pause.
- clear  input  1  single-cycle pulse; zeroes time, returns to IDLE.
- lap  input  1  single-cycle pulse; lap freeze (optional feature only).
- cs_ones  output  4  centiseconds units, BCD 0-9.
- cs_tens  output  4  centiseconds tens, BCD 0-9.
- s_ones  output  4  seconds units, BCD 0-9.
- s_tens  output  4  seconds tens, BCD 0-5.
- m_ones  output  4  minutes units, BCD 0-9.
- m_tens  output  4  minutes tens, BCD 0-5.
- running  output  1  high in RUN.
- ovf  output  1  high in DONE (limit reached).
- lap_active  output  1  displayed digits are a frozen snapshot.

Behaviour:
- Reset (rst_n low, asynchronous): all digits 0, prescaler 0, state IDLE, running/ovf/lap_active 0. Everything is registered; no combinational input-to-output paths.
- FSM states: IDLE, RUN, PAUSE, DONE.
- IDLE: start_stop -> RUN.
- RUN: start_stop -> PAUSE; limit rollover -> DONE.
- PAUSE: start_stop -> RUN.
- DONE: start_stop ignored.
- clear from any state -> IDLE, digits 0, prescaler 0, lap_active 0.
- clear has priority over start_stop, lap and a coincident tick in the same cycle.
- Prescaler: 0..DIV-1, counts only in RUN. Holds its value in PAUSE, so a resume continues the partial interval. Zeroed on clear and on entry to RUN from IDLE.
- Tick: internal tick on the edge where the prescaler equals DIV-1 in RUN. The prescaler wraps to 0 and the digit chain increments on that same edge.
- Latency: start_stop sampled on edge E0 -> running=1 after E0. First increment becomes visible after edge E0+DIV.
- Digit chain: cascaded BCD with carries cs_ones(9) -> cs_tens(9) -> s_ones(9) -> s_tens(5) -> m_ones(9) -> m_tens(5). Each digit wraps to 0 on carry.
- Digits never leave their legal range; binary values 10-15 are never produced.
- Limit: a tick at 59:59.99 does not wrap. Digits hold 59:59.99, state -> DONE, ovf=1, running=0. ovf stays high until clear or reset.
- start_stop pulses arriving between ticks change state without disturbing the digits.
- A start_stop pulse in the same cycle as a tick: the tick completes (digits increment), then the state changes.
- Reset asserted mid-count: immediate return to the reset values, no tick completes.

Optional Feature:
- Macro: STOPWATCH_LAP_EN.
- Defined: lap in RUN or PAUSE with lap_active=0 captures the current digits into a snapshot register on that edge and sets lap_active=1. Output ports then show the snapshot while the internal count continues.
- Defined: lap with lap_active=1 releases the freeze; outputs show live digits from the next edge.
- Defined: lap is ignored in IDLE and DONE. Entry to DONE releases the freeze so 59:59.99 is shown. clear releases the freeze.
- Not defined: lap port present but ignored, lap_active tied 0, no snapshot registers, outputs always live.

Test Plan:
- Bench uses CLK_HZ=1000, TICK_HZ=100 (DIV=10).
- Reset, then start_stop at E0 -> running=1; digits 00:00.00 through edge E0+9, 00:00.01 after E0+10, 00:00.10 after E0+100.
- Run to 00:00.99, one more tick -> 00:01.00. Run to 00:59.99, one more tick -> 01:00.00.
- Pause after 4 prescaler cycles into an interval, wait 50 cycles, resume -> digits frozen during pause; next increment 6 cycles after resume.
- Preload by running to 59:59.99, one more tick -> digits hold 59:59.99, ovf=1, running=0. start_stop -> no change; clear -> 00:00.00, ovf=0, state IDLE.
- clear and start_stop in the same cycle while in RUN -> IDLE, digits 0, running=0. rst_n low mid-count -> all outputs 0 immediately.
- With STOPWATCH_LAP_EN: lap at 00:00.12 -> outputs hold 00:00.12, lap_active=1; after 30 more ticks a second lap -> outputs show 00:00.42. Without the macro: lap has no effect.
